addertree_accum_ctrl: RTL and testbench

//  Sequences multi-beat accumulation through the stage-2 compressor tree. Drives the tree's
//  13-bit pre_output feedback: zero on the first beat of a result, the previous resolved sum
//  on later beats. Counts beats per result and returns the final sum over a valid/ready port.

---
 rtl/addertree_accum_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_addertree_accum_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addertree_accum_ctrl.sv
// -----------------------------------------------------------------------------
// addertree_accum_ctrl
//
// Sequences multi-beat accumulation through the stage-2 compressor tree.
// The tree adds the current operand beat to the pre_output feedback. This block
// supplies that feedback: zero on the first beat of a result, and the previous
// resolved sum on every later beat. It counts beats per result. It returns the
// final sum to the output/activation stage over a valid/ready port.
//
// Optional feature macro: ACCUM_SAT_EN
//   Defined   : a carry out of the tree on any accepted beat sets a sticky
//               overflow flag. From then on, feedback and result saturate to
//               all-ones. out_ovf reports the flag with the result.
//   Undefined : tree_cout is ignored, sums wrap modulo 2^ACC_W, out_ovf = 0.
//
// Ports
//   clk, reset_n  clock (rising edge); asynchronous active-low reset
//   start         pulse: begin a result and latch cfg_len (honoured in IDLE only)
//   clear         synchronous abort to IDLE; highest priority
//   cfg_len       beats per result (0 is treated as 1)
//   in_valid      operand beat presented to the tree this cycle
//   in_ready      controller accepts a beat this cycle (ACC state)
//   tree_en       accepted beat; operand/pipeline capture enable
//   tree_sum      resolved tree sum for the presented beat
//   tree_cout     carry beyond bit ACC_W for the presented beat
//   pre_output    feedback to the tree
//   out_valid     out_data holds a finished result
//   out_ready     downstream accepts out_data
//   out_data      final accumulated result
//   out_ovf       overflow seen in this result
//   busy          controller is not IDLE
//   beat_cnt      beats remaining in the current result
// -----------------------------------------------------------------------------
module addertree_accum_ctrl #(
   parameter int LEN_W = 8,
   parameter int ACC_W = 13
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             clear,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             tree_en,
   input  logic [ACC_W-1:0] tree_sum,
   input  logic             tree_cout,
   output logic [ACC_W-1:0] pre_output,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf,
   output logic             busy,
   output logic [LEN_W-1:0] beat_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q;
   logic             first_q;
   logic [LEN_W-1:0] beat_cnt_q;
   logic [ACC_W-1:0] out_data_q;
   logic             out_valid_q;

   logic             accept;
   logic             last_beat;
   logic [ACC_W-1:0] beat_val;   // value this beat contributes to acc/result
   logic             beat_ovf;   // overflow status after this beat

   assign in_ready  = (state_q == S_ACC);
   assign tree_en   = in_valid & in_ready;
   assign accept    = tree_en & ~clear;
   assign last_beat = accept & (beat_cnt_q == LEN_W'(1));

   // Feedback is selected from registers only, so there is no combinational
   // path from tree_sum back into the tree.
   assign pre_output = first_q ? '0 : acc_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign busy       = (state_q != S_IDLE);
   assign beat_cnt   = beat_cnt_q;

`ifdef ACCUM_SAT_EN
   logic ovf_q;
   logic out_ovf_q;

   // Once the sticky flag is set, every later sum is forced to all-ones.
   assign beat_ovf = ovf_q | tree_cout;
   assign beat_val = beat_ovf ? '1 : tree_sum;
   assign out_ovf  = out_ovf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q     <= 1'b0;
         out_ovf_q <= 1'b0;
      end else if (clear || (state_q == S_IDLE && start)) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= beat_ovf;
         if (last_beat) out_ovf_q <= beat_ovf;
      end
   end
`else
   logic unused_tree_cout;

   assign unused_tree_cout = tree_cout;
   assign beat_ovf         = 1'b0;
   assign beat_val         = tree_sum;
   assign out_ovf          = beat_ovf;
`endif

   // State register
   // NOTE: non-blocking assignments in clocked blocks. Every register then
   // samples values from before the edge, whatever the statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   // NOTE: state_d gets a default before any branch, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:  if (start)     state_d = S_ACC;
            S_ACC:   if (last_beat) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
         endcase
      end
   end

   // Accumulator, beat counter and result register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q       <= '0;
         first_q     <= 1'b1;
         beat_cnt_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (clear) begin
         // out_data keeps the last finished result across an abort.
         acc_q       <= '0;
         first_q     <= 1'b1;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  beat_cnt_q <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                  first_q    <= 1'b1;
               end
            end
            S_ACC: begin
               if (accept) begin
                  acc_q      <= beat_val;
                  first_q    <= 1'b0;
                  beat_cnt_q <= beat_cnt_q - LEN_W'(1);
                  if (last_beat) begin
                     out_data_q  <= beat_val;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  first_q     <= 1'b1;
                  acc_q       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addertree_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addertree_accum_ctrl
//
// The bench plays the role of the compressor tree. Each accepted beat adds a
// random operand to the running total that the controller should be feeding
// back. The reference keeps that total as a plain integer sum. When
// ACCUM_SAT_EN is defined, it also keeps a sticky overflow flag.
// -----------------------------------------------------------------------------
module tb_addertree_accum_ctrl;

   localparam int LEN_W = 8;
   localparam int ACC_W = 13;
   localparam logic [ACC_W-1:0] ALL_ONES = '1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start, clear, in_valid, out_ready, tree_cout;
   logic [LEN_W-1:0] cfg_len;
   logic [ACC_W-1:0] tree_sum;
   logic             in_ready, tree_en, out_valid, out_ovf, busy;
   logic [ACC_W-1:0] pre_output, out_data;
   logic [LEN_W-1:0] beat_cnt;

   int               vectors     = 0;
   int               miscompares = 0;
   logic [ACC_W-1:0] exp_out_data = '0;
   logic             exp_out_ovf  = 1'b0;
   int               op_q[$];

   always #5 clk = ~clk;

   addertree_accum_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .clear      (clear),
      .cfg_len    (cfg_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tree_en    (tree_en),
      .tree_sum   (tree_sum),
      .tree_cout  (tree_cout),
      .pre_output (pre_output),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ovf    (out_ovf),
      .busy       (busy),
      .beat_cnt   (beat_cnt)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      start = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tree_sum = '0; tree_cout = 1'b0; cfg_len = '0;
   endtask

   // One result. Inputs are driven on the falling edge. Outputs are checked
   // 1 ns later, well away from the rising edge. Setting abort_at stops the
   // result after that many beats, using clear (or reset_n when abort_rst is set).
   task automatic run_result(input int cfg, input int gap_pct, input int hold,
                             input int abort_at, input bit abort_rst);
      int               n      = (cfg == 0) ? 1 : cfg;
      int               done   = 0;
      int               cycles = 0;
      int               n_en   = 0;
      int               op;
      logic [ACC_W-1:0] acc = '0;
      logic             ovf = 1'b0;
      logic [14:0]      raw;

      @(negedge clk);
      start = 1'b1; cfg_len = LEN_W'(cfg); in_valid = 1'b0; out_ready = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL idle_before_start: busy=%0b want 0", busy);
      end
      @(negedge clk);
      start = 1'b0; cfg_len = LEN_W'($urandom);

      while (done < n) begin
         if (cycles > 3000) begin
            miscompares++; vectors++;
            $display("FAIL beat_timeout: beats=%0d want %0d", done, n);
            idle_inputs();
            return;
         end
         cycles++;
         if (abort_at != 0 && done == abort_at) begin
            if (!abort_rst) begin
               clear = 1'b1; in_valid = 1'b1; start = 1'b1;
               tree_sum = ACC_W'($urandom);
               @(negedge clk);
               clear = 1'b0; in_valid = 1'b0; start = 1'b0;
               #1;
               vectors++;
               if ({busy, out_valid, in_ready, tree_en, beat_cnt, pre_output, out_data} !==
                   {1'b0, 1'b0, 1'b0, 1'b0, LEN_W'(0), ACC_W'(0), exp_out_data}) begin
                  miscompares++;
                  $display("FAIL clear_abort: busy=%0b ov=%0b rdy=%0b en=%0b cnt=%0d pre=%h data=%h want 0/0/0/0/0/0/%h",
                           busy, out_valid, in_ready, tree_en, beat_cnt, pre_output, out_data, exp_out_data);
               end
            end else begin
               reset_n = 1'b0; in_valid = 1'b0;
               exp_out_data = '0; exp_out_ovf = 1'b0;
               #1;
               vectors++;
               if ({busy, out_valid, in_ready, beat_cnt, pre_output, out_data, out_ovf} !==
                   {1'b0, 1'b0, 1'b0, LEN_W'(0), ACC_W'(0), ACC_W'(0), 1'b0}) begin
                  miscompares++;
                  $display("FAIL reset_abort: busy=%0b ov=%0b rdy=%0b cnt=%0d pre=%h data=%h ovf=%0b want all 0",
                           busy, out_valid, in_ready, beat_cnt, pre_output, out_data, out_ovf);
               end
               @(negedge clk);
               reset_n = 1'b1;
            end
            return;
         end

         in_valid = ($urandom_range(99) >= gap_pct);
         if (in_valid && op_q.size() != 0) op = op_q.pop_front();
         else                              op = int'($urandom_range(0, 'h1FFF));
         raw       = 15'(acc) + 15'(op);
         tree_sum  = raw[ACC_W-1:0];
         tree_cout = |raw[14:13];
         #1;
         vectors++;
         if ({busy, in_ready, tree_en, pre_output, beat_cnt} !==
             {1'b1, 1'b1, in_valid, acc, LEN_W'(n - done)}) begin
            miscompares++;
            $display("FAIL acc_beat%0d: busy=%0b rdy=%0b en=%0b pre=%h cnt=%0d want 1/1/%0b/%h/%0d",
                     done, busy, in_ready, tree_en, pre_output, beat_cnt, in_valid, acc, n - done);
         end
         if (tree_en) n_en++;
         if (in_valid) begin
            done++;
`ifdef ACCUM_SAT_EN
            ovf = ovf | tree_cout;
            acc = ovf ? ALL_ONES : raw[ACC_W-1:0];
`else
            acc = raw[ACC_W-1:0];
`endif
         end
         @(negedge clk);
      end

      in_valid = 1'b0; tree_sum = '0; tree_cout = 1'b0;
      exp_out_data = acc;
      exp_out_ovf  = ovf;
      vectors++;
      if (n_en != n) begin
         miscompares++; $display("FAIL tree_en_count: got %0d want %0d", n_en, n);
      end

      for (int h = 0; h <= hold; h++) begin
         out_ready = (h == hold);
         start     = (h == 1);
         #1;
         vectors++;
         if ({out_valid, out_data, out_ovf, in_ready, busy, beat_cnt} !==
             {1'b1, exp_out_data, exp_out_ovf, 1'b0, 1'b1, LEN_W'(0)}) begin
            miscompares++;
            $display("FAIL out_hold%0d: ov=%0b data=%h ovf=%0b rdy=%0b busy=%0b cnt=%0d want 1/%h/%0b/0/1/0",
                     h, out_valid, out_data, out_ovf, in_ready, busy, beat_cnt, exp_out_data, exp_out_ovf);
         end
         @(negedge clk);
      end
      out_ready = 1'b0; start = 1'b0;
      #1;
      vectors++;
      if ({busy, out_valid, out_data, pre_output} !== {1'b0, 1'b0, exp_out_data, ACC_W'(0)}) begin
         miscompares++;
         $display("FAIL back_to_idle: busy=%0b ov=%0b data=%h pre=%h want 0/0/%h/0",
                  busy, out_valid, out_data, pre_output, exp_out_data);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      in_valid = 1'b1;
      #1;
      vectors++;
      if ({busy, in_ready, tree_en, out_valid, out_ovf, beat_cnt, pre_output, out_data} !==
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LEN_W'(0), ACC_W'(0), ACC_W'(0)}) begin
         miscompares++;
         $display("FAIL reset_state: busy=%0b rdy=%0b en=%0b ov=%0b ovf=%0b cnt=%0d pre=%h data=%h want all 0",
                  busy, in_ready, tree_en, out_valid, out_ovf, beat_cnt, pre_output, out_data);
      end
      @(negedge clk);
      reset_n = 1'b1; in_valid = 1'b0;
   endtask

   task automatic test_directed();
      op_q = '{'h010, 'h015, 'h01B};
      run_result(3, 0, 0, 0, 1'b0);
      vectors++;
      if (out_data !== 13'h040) begin
         miscompares++; $display("FAIL directed_sum: got %h want 040", out_data);
      end
      op_q = '{'h1AB};
      run_result(0, 0, 0, 0, 1'b0);
      vectors++;
      if (out_data !== 13'h1AB) begin
         miscompares++; $display("FAIL cfg_zero_sum: got %h want 1ab", out_data);
      end
   endtask

   task automatic test_backpressure();
      run_result(5, 30, 5, 0, 1'b0);
   endtask

   task automatic test_abort();
      run_result(4, 0, 0, 2, 1'b0);
      run_result(4, 20, 1, 0, 1'b0);
      run_result(4, 0, 0, 2, 1'b1);
      run_result(2, 0, 0, 0, 1'b0);
   endtask

   task automatic test_saturation();
      op_q = '{'h2005, 'h003};
      run_result(2, 0, 0, 0, 1'b0);
`ifdef ACCUM_SAT_EN
      vectors++;
      if ({out_data, out_ovf} !== {ALL_ONES, 1'b1}) begin
         miscompares++; $display("FAIL sat_result: data=%h ovf=%0b want 1fff/1", out_data, out_ovf);
      end
`else
      vectors++;
      if ({out_data, out_ovf} !== {13'h008, 1'b0}) begin
         miscompares++; $display("FAIL wrap_result: data=%h ovf=%0b want 008/0", out_data, out_ovf);
      end
`endif
      op_q = '{'h001, 'h002};
      run_result(2, 0, 0, 0, 1'b0);
      vectors++;
      if ({out_data, out_ovf} !== {13'h003, 1'b0}) begin
         miscompares++; $display("FAIL ovf_cleared: data=%h ovf=%0b want 003/0", out_data, out_ovf);
      end
   endtask

   task automatic test_idle_misc();
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b1;
      #1;
      vectors++;
      if ({tree_en, in_ready, busy} !== 3'b000) begin
         miscompares++; $display("FAIL idle_inputs_ignored: en=%0b rdy=%0b busy=%0b want 0/0/0",
                                tree_en, in_ready, busy);
      end
      start = 1'b1; cfg_len = 8'd3;
      @(negedge clk);
      clear = 1'b0; start = 1'b0; in_valid = 1'b0;
      #1;
      vectors++;
      if ({busy, beat_cnt, out_data} !== {1'b0, LEN_W'(0), exp_out_data}) begin
         miscompares++; $display("FAIL clear_over_start: busy=%0b cnt=%0d data=%h want 0/0/%h",
                                busy, beat_cnt, out_data, exp_out_data);
      end
   endtask

   task automatic test_long_gaps();
      run_result(255, 50, 2, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++)
         run_result(int'($urandom_range(1, 20)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 3)), 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_abort();
      test_saturation();
      test_idle_misc();
      test_long_gaps();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
